clock_ctrl: RTL and testbench
=============================

// Module: clock_ctrl
// PURPOSE
// - Control stage directly upstream of the six-field time/date counter bank (second, minute, hour, day, month, year).
// - Generates the 1 Hz tick, the inc/dec/en strobes and the carry cascade between fields.
// - Supplies the days-in-month limit (leap-aware) and the hour limit.
// - Runs the user set-mode FSM (mode/up/down buttons) and clamps day after month/year edits.
// PARAMETERS
// - TICK_DIV   50_000_000  clk cycles per seconds tick (>=4)
// - HOUR_MAX   23          value driven on hour_num
// PORTS
// - clk        in   1  system clock, rising edge
// - reset_n    in   1  synchronous reset, active-low
// - btn_mode   in   1  debounced level; rising edge advances edit field
// - btn_up     in   1  debounced level; rising edge increments selected field
// - btn_down   in   1  debounced level; rising edge decrements selected field
// - day        in   5  current day count (1..31)
// - month      in   4  current month count (1..12)
// - year       in   7  current year count, 0..99 = 2000..2099
// - done_inc   in   5  per-field wrap pulses [0]=sec .. [4]=month
// - inc        out  6  one-cycle increment strobes [0]=sec .. [5]=year
// - dec        out  6  one-cycle decrement strobes
// - en         out  6  per-field count enables
// - day_num    out  5  days in current month (28/29/30/31)
// - hour_num   out  5  constant HOUR_MAX
// - edit_field out  3  0=RUN, 1=sec, 2=min, 3=hour, 4=day, 5=month, 6=year
// - blink      out  1  high in first half of each tick period while editing, else 0
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): state RUN, prescaler=0, inc=0, dec=0, en=6'h3F, edit_field=0, blink=0, edge-detect regs=0.
// - All strobe outputs are registered; at most one pulse per bit per cycle.
// - Prescaler counts 0..TICK_DIV-1; it wraps and runs in every state. Leaving edit for RUN clears it to 0.
// - FSM: RUN->E_SEC->E_MIN->E_HOUR->E_DAY->E_MON->E_YEAR->RUN, one step per btn_mode rising edge. edit_field = state code.
// - RUN: en=6'h3F.
//   - Prescaler==TICK_DIV-1 in cycle n -> inc[0]=1 in cycle n+1.
//   - done_inc[k]=1 in cycle n -> inc[k+1]=1 in cycle n+1 (k=0..4). A full rollover therefore staggers inc[1..5] by 1 cycle each.
// - EDIT states: en = one-hot of the selected field; no ticks reach inc[0]; done_inc is ignored (no cascade).
//   - Rising edge of btn_up -> inc[field]=1 for exactly one cycle, next cycle.
//   - Rising edge of btn_down -> dec[field]=1 for exactly one cycle, next cycle.
//   - A held button gives one pulse only.
// - Simultaneous events:
//   - up+down edges in the same cycle -> neither pulses.
//   - mode edge with up/down edge -> mode wins, up/down dropped.
//   - A mode edge in the same cycle as a pending RUN tick -> tick dropped.
// - day_num is combinational from month/year:
//   - 4,6,9,11 -> 30.
//   - 2 -> 29 if year[1:0]==0, else 28.
//   - Others -> 31.
//   - Out-of-range month -> 31.
// - Day clamp, any state: if day>day_num and no clamp pulse was issued last cycle -> dec[3]=1. This gives one pulse per 2 cycles until day<=day_num. While clamping, en[3] is forced 1 and user/tick strobes to field 3 are suppressed.
// - Reset mid-operation aborts cascade, clamp and edit immediately; no partial strobes after the reset edge.
// TESTING (TICK_DIV=4)
// - Release reset -> inc[0] pulses at cycles 4, 8, 12 after release, 1 cycle wide, en=6'h3F.
// - RUN, done_inc=5'b00001 at cycle n, then 5'b00010 at n+1 -> inc[1] at n+1, inc[2] at n+2.
// - 3 mode edges -> edit_field=3, en=6'b000100. Hold btn_up 10 cycles -> a single inc[2] pulse. No inc[0] while in edit.
// - month=2, year=23, day=31 -> day_num=28; dec[3] on alternate cycles until day=28 (3 pulses). With year=24 -> day_num=29.
// - up and down edges together -> no strobes. mode+up together -> edit_field advances, no inc.
// - reset_n low during E_MON with dec pending -> next cycle edit_field=0, inc=dec=0, en=6'h3F, first tick 4 cycles after release.

Source files
------------

// File: rtl/clock_ctrl_if.sv
// Control-stage bus between clock_ctrl and the time/date counter bank.
// The master drives buttons and counter state. The slave returns strobes, enables and limits.
interface clock_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [4:0] done_inc;
  logic [5:0] inc;
  logic [5:0] dec;
  logic [5:0] en;
  logic [4:0] day_num;
  logic [4:0] hour_num;
  logic [2:0] edit_field;
  logic       blink;

  modport master (
    output btn_mode, btn_up, btn_down, day, month, year, done_inc,
    input  inc, dec, en, day_num, hour_num, edit_field, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, day, month, year, done_inc,
    output inc, dec, en, day_num, hour_num, edit_field, blink
  );
endinterface

// File: rtl/clock_ctrl.sv
// Time/date control stage: 1 Hz prescaler, carry cascade, set-mode FSM,
// leap-aware days-in-month limit and the day clamp after month/year edits.
module clock_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOUR_MAX = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  clock_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    E_SEC  = 3'd1,
    E_MIN  = 3'd2,
    E_HOUR = 3'd3,
    E_DAY  = 3'd4,
    E_MON  = 3'd5,
    E_YEAR = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          r_mode_q, r_up_q, r_down_q, r_clamp_q;
  logic [5:0]    r_inc, r_dec;

  logic       w_mode_rise, w_up_rise, w_down_rise;
  logic       w_tick, w_leap, w_clamp_need, w_clamp_pulse, w_blink;
  logic [4:0] w_day_num;
  logic [5:0] w_sel, w_en, w_inc_nxt, w_dec_nxt;

  assign w_mode_rise = bus.btn_mode & ~r_mode_q;
  assign w_up_rise   = bus.btn_up   & ~r_up_q;
  assign w_down_rise = bus.btn_down & ~r_down_q;
  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));

  // Gregorian rule reduces to year%4 over 2000..2099
  assign w_leap = ((bus.year & 7'd3) == 7'd0);

  always_comb begin
    w_day_num = 5'd31;
    case (bus.month)
      4'd4, 4'd6, 4'd9, 4'd11: w_day_num = 5'd30;
      4'd2:                    w_day_num = w_leap ? 5'd29 : 5'd28;
      default:                 w_day_num = 5'd31;
    endcase
  end

  assign w_clamp_need  = (bus.day > w_day_num);
  assign w_clamp_pulse = w_clamp_need & ~r_clamp_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_rise)
      w_state_nxt = (r_state == E_YEAR) ? RUN : state_t'(r_state + 3'd1);
  end

  // Output logic: enables, blink and next-cycle strobe values
  always_comb begin
    w_sel     = '0;
    w_en      = 6'h3F;
    w_inc_nxt = '0;
    w_dec_nxt = '0;
    w_blink   = 1'b0;
    case (r_state)
      E_SEC:   w_sel = 6'b000001;
      E_MIN:   w_sel = 6'b000010;
      E_HOUR:  w_sel = 6'b000100;
      E_DAY:   w_sel = 6'b001000;
      E_MON:   w_sel = 6'b010000;
      E_YEAR:  w_sel = 6'b100000;
      default: w_sel = '0;
    endcase
    if (r_state == RUN) begin
      w_inc_nxt = {bus.done_inc, w_tick & ~w_mode_rise};
    end else begin
      w_en    = w_sel;
      w_blink = (r_presc < PW'(TICK_DIV / 2));
      if (!w_mode_rise && w_up_rise && !w_down_rise) w_inc_nxt = w_sel;
      if (!w_mode_rise && w_down_rise && !w_up_rise) w_dec_nxt = w_sel;
    end
    // Clamp owns the day field until it is back in range
    if (w_clamp_need) begin
      w_en[3]      = 1'b1;
      w_inc_nxt[3] = 1'b0;
      w_dec_nxt[3] = w_clamp_pulse;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_mode_q  <= 1'b0;
      r_up_q    <= 1'b0;
      r_down_q  <= 1'b0;
      r_clamp_q <= 1'b0;
      r_inc     <= '0;
      r_dec     <= '0;
    end else begin
      r_mode_q  <= bus.btn_mode;
      r_up_q    <= bus.btn_up;
      r_down_q  <= bus.btn_down;
      r_clamp_q <= w_clamp_pulse;
      r_inc     <= w_inc_nxt;
      r_dec     <= w_dec_nxt;
      // Returning to RUN restarts the second from zero
      if (w_mode_rise && r_state == E_YEAR) r_presc <= '0;
      else if (w_tick)                      r_presc <= '0;
      else                                  r_presc <= r_presc + 1'b1;
    end
  end

  assign bus.inc        = r_inc;
  assign bus.dec        = r_dec;
  assign bus.en         = w_en;
  assign bus.blink      = w_blink;
  assign bus.edit_field = r_state;
  assign bus.day_num    = w_day_num;
  assign bus.hour_num   = 5'(HOUR_MAX);
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the control rules.
module tb_clock_ctrl;
  localparam int TICK_DIV = 4;
  localparam int HOUR_MAX = 23;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   auto_day = 1'b0;

  clock_ctrl_if bus();

  clock_ctrl #(.TICK_DIV(TICK_DIV), .HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: edit field number, cycles into the current second,
  // previous button levels, clamp-issued flag, registered strobes
  int         m_field, m_cnt;
  bit         m_pm, m_pu, m_pd, m_clamp;
  logic [5:0] m_inc, m_dec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dim(input int mo, input int yr);
    if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [5:0] exp_en();
    logic [5:0] e;
    e = (m_field == 0) ? 6'h3F : 6'(1 << (m_field - 1));
    if (int'(bus.day) > dim(int'(bus.month), int'(bus.year))) e[3] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_field = 0; m_cnt = 0;
    m_pm = 0; m_pu = 0; m_pd = 0; m_clamp = 0;
    m_inc = '0; m_dec = '0;
  endtask

  task automatic model_step();
    bit mr, ur, dr, need;
    logic [5:0] ni, nd;
    mr = bus.btn_mode && !m_pm;
    ur = bus.btn_up   && !m_pu;
    dr = bus.btn_down && !m_pd;
    ni = '0; nd = '0;
    if (m_field == 0) begin
      if (m_cnt == TICK_DIV - 1 && !mr) ni[0] = 1'b1;
      for (int k = 0; k < 5; k++) if (bus.done_inc[k]) ni[k+1] = 1'b1;
    end else if (!mr && ur && !dr) begin
      ni[m_field-1] = 1'b1;
    end else if (!mr && dr && !ur) begin
      nd[m_field-1] = 1'b1;
    end
    need = int'(bus.day) > dim(int'(bus.month), int'(bus.year));
    if (need) begin
      ni[3] = 1'b0;
      nd[3] = !m_clamp;
    end
    m_clamp = need && !m_clamp;
    if (mr && m_field == 6) m_cnt = 0;
    else                    m_cnt = (m_cnt + 1) % TICK_DIV;
    if (mr) m_field = (m_field + 1) % 7;
    m_pm = bus.btn_mode; m_pu = bus.btn_up; m_pd = bus.btn_down;
    m_inc = ni; m_dec = nd;
  endtask

  // One clock: advance model with pre-edge inputs, then compare after the edge
  task automatic cyc();
    if (!reset_n) model_reset();
    else          model_step();
    @(posedge clk); #1;
    check("inc",      32'(bus.inc),        32'(m_inc));
    check("dec",      32'(bus.dec),        32'(m_dec));
    check("en",       32'(bus.en),         32'(exp_en()));
    check("field",    32'(bus.edit_field), 32'(m_field));
    check("blink",    32'(bus.blink),      32'((m_field != 0) && (m_cnt < TICK_DIV / 2)));
    check("day_num",  32'(bus.day_num),    32'(dim(int'(bus.month), int'(bus.year))));
    check("hour_num", 32'(bus.hour_num),   32'(HOUR_MAX));
    if (auto_day && bus.dec[3] && bus.day > 5'd1) bus.day = bus.day - 5'd1;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1; cyc();
    bus.btn_mode = 1'b0; cyc();
  endtask

  initial begin
    int cnt, cnt0;
    reset_n = 1'b0;
    bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.day = 5'd1; bus.month = 4'd1; bus.year = 7'd0; bus.done_inc = '0;
    model_reset();
    cyc(); cyc();
    check("rst_inc",   32'(bus.inc), 32'h0);
    check("rst_en",    32'(bus.en), 32'h3F);
    check("rst_field", 32'(bus.edit_field), 32'h0);

    // Tick cadence after reset release
    reset_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      check($sformatf("tick_c%0d", i), 32'(bus.inc[0]), 32'((i % 4) == 0));
    end

    // Carry cascade
    bus.done_inc = 5'b00001; cyc();
    check("casc_inc1", 32'(bus.inc[1]), 32'h1);
    bus.done_inc = 5'b00010; cyc();
    check("casc_inc2", 32'(bus.inc[2]), 32'h1);
    bus.done_inc = '0; cyc();
    check("casc_idle", 32'(bus.inc[5:1]), 32'h0);

    // Edit the hour field; held up button yields one pulse
    press_mode(); press_mode(); press_mode();
    check("edit_field3", 32'(bus.edit_field), 32'h3);
    check("edit_en",     32'(bus.en), 32'h04);
    cnt = 0; cnt0 = 0;
    bus.btn_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cnt  += int'(bus.inc[2]);
      cnt0 += int'(bus.inc[0]);
    end
    bus.btn_up = 1'b0; cyc();
    check("hold_up_pulses", 32'(cnt), 32'd1);
    check("edit_no_tick",   32'(cnt0), 32'd0);

    // up+down together cancel; mode+up: mode wins
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; cyc();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; cyc();
    check("updown_inc", 32'(bus.inc), 32'h0);
    check("updown_dec", 32'(bus.dec), 32'h0);
    bus.btn_mode = 1'b1; bus.btn_up = 1'b1; cyc();
    check("modeup_field", 32'(bus.edit_field), 32'h4);
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; cyc();
    check("modeup_inc", 32'(bus.inc), 32'h0);

    // Day clamp in February of a non-leap year
    auto_day = 1'b1;
    bus.month = 4'd2; bus.year = 7'd23; bus.day = 5'd31;
    #1 check("feb23_num", 32'(bus.day_num), 32'd28);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      cnt += int'(bus.dec[3]);
    end
    check("clamp_pulses", 32'(cnt), 32'd3);
    check("clamp_day",    32'(bus.day), 32'd28);
    bus.year = 7'd24;
    #1 check("feb24_num", 32'(bus.day_num), 32'd29);
    auto_day = 1'b0;

    // Reset in E_MON with a clamp decrement pending
    press_mode();
    check("emon_field", 32'(bus.edit_field), 32'h5);
    bus.month = 4'd4; bus.day = 5'd31; cyc();
    reset_n = 1'b0; cyc();
    check("rst2_field", 32'(bus.edit_field), 32'h0);
    check("rst2_inc",   32'(bus.inc), 32'h0);
    check("rst2_dec",   32'(bus.dec), 32'h0);
    check("rst2_en",    32'(bus.en), 32'h3F);
    bus.day = 5'd30; reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("rst2_tick_c%0d", i), 32'(bus.inc[0]), 32'(i == 4));
    end

    // Randomized traffic against the model
    auto_day = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) bus.btn_mode = ~bus.btn_mode;
      if ($urandom_range(2) == 0) bus.btn_up   = ~bus.btn_up;
      if ($urandom_range(2) == 0) bus.btn_down = ~bus.btn_down;
      bus.done_inc = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd0;
      if ($urandom_range(15) == 0) bus.month = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) bus.year  = 7'($urandom_range(99));
      if ($urandom_range(20) == 0) bus.day   = 5'($urandom_range(31, 1));
      reset_n = ($urandom_range(199) != 0);
      cyc();
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
